// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges the cache's atomic 256-bit line transfer to
// physical memory's 4-beat x 64-bit burst protocol. The full line lives in
// an internal buffer; the cache sees one resp_o pulse per completed line.
module cacheline_adaptor (
    input  logic         clk,
    input  logic         rst,

    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    output logic         resp_o,

    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q;
    logic [255:0]   buf_q;
    logic [31:0]    addr_q;

    // The line buffer is visible at all times; it only holds a filled line in RD_DONE.
    assign line_o    = buf_q;
    // Masking keeps the burst address 32-byte aligned without dropping stored bits.
    assign address_o = addr_q & ~32'h0000_001F;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and memory/cache handshake outputs.
    always_comb begin
        state_d = state_q;
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        burst_o = '0;
        case (state_q)
            IDLE: begin
                if (write_i)     state_d = WR_BURST;
                else if (read_i) state_d = RD_BURST;
            end
            RD_BURST: begin
                read_o = 1'b1;
                if (resp_i && cnt_q == 2'd3) state_d = RD_DONE;
            end
            RD_DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            WR_BURST: begin
                write_o = 1'b1;
                burst_o = buf_q[{cnt_q, 6'd0} +: 64];
                if (resp_i && cnt_q == 2'd3) state_d = WR_DONE;
            end
            WR_DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latching, beat counting and read-beat assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            buf_q  <= '0;
            addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (write_i) begin
                        buf_q  <= line_i;
                        addr_q <= address_i;
                        cnt_q  <= '0;
                    end else if (read_i) begin
                        addr_q <= address_i;
                        cnt_q  <= '0;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        buf_q[{cnt_q, 6'd0} +: 64] <= burst_i;
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                WR_BURST: begin
                    if (resp_i) cnt_q <= cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts the cache's single-transfer 256-bit line interface into the 4-beat, 64-bit burst protocol of physical memory. Sits directly downstream of the cache controller: it consumes the controller's line read (fill) and line write (writeback) requests and returns one `resp_o` pulse per completed line. It holds the full line in an internal buffer, so the cache sees an atomic 256-bit transfer.

## Interface
- No parameters. Line is 256 bits, beat is 64 bits, burst is 4 beats, address is 32 bits.
- `clk` in 1: clock, rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `line_i` in 256: line to write back; sampled on request acceptance.
- `line_o` out 256: filled line; valid while `resp_o`=1 for a read.
- `address_i` in 32: line address from cache; sampled on acceptance.
- `read_i` in 1: line fill request; held by cache until `resp_o`.
- `write_i` in 1: line writeback request; held by cache until `resp_o`.
- `resp_o` out 1: one-cycle completion pulse.
- `burst_i` in 64: read beat from memory.
- `burst_o` out 64: write beat to memory.
- `address_o` out 32: burst address, always 32-byte aligned.
- `read_o` out 1: burst read request to memory.
- `write_o` out 1: burst write request to memory.
- `resp_i` in 1: memory beat strobe; each high cycle transfers one beat.

## Operation
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE. Beat counter `cnt` is 2 bits.
- IDLE:
  - `write_i`=1 → latch `line_i` into buffer and `address_i` into the address register, `cnt`←0, go to WR_BURST.
  - else `read_i`=1 → latch address, `cnt`←0, go to RD_BURST.
  - If both requests are high, write wins.
  - `resp_i` is ignored in IDLE.
- RD_BURST:
  - `read_o`=1.
  - On `resp_i`=1: buffer[64·cnt +: 64] ← `burst_i`; `cnt`←`cnt`+1.
  - On `resp_i`=1 with `cnt`=3 → RD_DONE.
- RD_DONE: `resp_o`=1, `line_o`=buffer, then go to IDLE.
- WR_BURST:
  - `write_o`=1, `burst_o`=buffer[64·cnt +: 64].
  - On `resp_i`=1: `cnt`←`cnt`+1.
  - On `resp_i`=1 with `cnt`=3 → WR_DONE.
- WR_DONE: `resp_o`=1, then go to IDLE.
- Beat order: beat 0 = line bits [63:0], through beat 3 = bits [255:192].
- `address_o` = latched address with bits [4:0] forced to 0. It is held constant for the whole burst.
- `line_o` is driven from the registered buffer at all times. Its contents are defined only in RD_DONE.
- `read_i`/`write_i` changing mid-burst is ignored; the latched transfer completes.

## Timing
- Reset values:
  - state=IDLE, `cnt`=0, buffer=0, address register=0.
  - `resp_o`=0, `read_o`=0, `write_o`=0, `burst_o`=0, `address_o`=0, `line_o`=0.
- Accept: request seen in IDLE at cycle t → `read_o`/`write_o` high from cycle t+1.
- Minimum latency, with `resp_i` high on 4 consecutive cycles t+1..t+4: `resp_o` at t+5.
- Each cycle `resp_i` is low adds one cycle of latency. Gaps between beats are allowed, and `cnt` holds during them.
- `resp_o` is high exactly one cycle. The cache drops its request at that edge, so IDLE at t+6 sees no request.
- Back-to-back operation: a writeback followed by a fill is two separate transactions. The fill is accepted in the IDLE cycle after WR_DONE.
- `read_o`/`write_o` deassert in the DONE cycle and are never both high.
- Reset mid-burst: the next cycle is IDLE with all outputs low. Stray memory `resp_i` beats are ignored and no `resp_o` is issued.
- `cnt` wrap 3→0 coincides with the DONE transition. No fifth beat is ever consumed.

## Test plan
- **Fill, back-to-back beats.**
  - Stimulus: `read_i` with addr 0x0000_1234; `resp_i` high 4 cycles with beats 0xA0…, 0xA1…, 0xA2…, 0xA3….
  - Required: `address_o`=0x0000_1220; `resp_o` 5 cycles after acceptance; `line_o`={A3,A2,A1,A0}.
- **Writeback.**
  - Stimulus: `write_i` with `line_i`={D,C,B,A} (64-bit words) and addr 0x8000_00FF.
  - Required: `address_o`=0x8000_00E0; `burst_o` shows A,B,C,D on successive `resp_i` cycles; `write_o` high 4 cycles; single `resp_o`.
- **Stalled beats.**
  - Stimulus: fill with `resp_i` pattern 1,0,0,1,1,0,1.
  - Required: correct line assembled; `resp_o` 1 cycle after the 7th burst cycle; `cnt` holds during gaps.
- **Eviction then fill.**
  - Stimulus: the cache's dirty-miss sequence, a writeback then a fill to a different line.
  - Required: two `resp_o` pulses; `write_o` and `read_o` never overlap; the fill address is latched fresh.
- **Reset mid-burst.**
  - Stimulus: assert `rst` after 2 read beats.
  - Required: next cycle all outputs 0; further `resp_i` pulses produce no `resp_o`; a new fill then completes correctly.
- **Simultaneous requests.**
  - Stimulus: `read_i`=`write_i`=1 in IDLE.
  - Required: `write_o` asserts; `read_o` stays 0 for that transaction.
